// File: rtl/par_serial_tx.sv
`timescale 1ns/1ps
// par_serial_tx: shifts mux bytes out one bit per clk_32f, inserting COM_CHAR when idle and after reset.
// Optional macro PS_LSB_FIRST_EN: transmit each byte LSB first instead of MSB first.
module par_serial_tx #(
    parameter logic [7:0]  COM_CHAR = 8'hBC,
    parameter int unsigned INIT_COM = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       sync_out,
    output logic       active_out
);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

    localparam logic [3:0] LAST_COM = 4'(INIT_COM - 1);

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] cur_byte_q, cur_byte_d;
    logic       cur_is_data_q, cur_is_data_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic       data_out_q, data_out_d;
    logic       sync_out_q, sync_out_d;
    logic       active_out_q, active_out_d;
    logic       boundary;
    logic       last_init;

    assign boundary  = (bit_cnt_q == 3'd7);
    assign last_init = (com_cnt_q == LAST_COM);

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && boundary && last_init) begin
            state_d = RUN;
        end
    end

    // The final INIT boundary already loads under the RUN rule, so valid data can follow directly.
    always_comb begin
        bit_cnt_d     = bit_cnt_q + 3'd1;
        cur_byte_d    = cur_byte_q;
        cur_is_data_d = cur_is_data_q;
        com_cnt_d     = com_cnt_q;
`ifdef PS_LSB_FIRST_EN
        data_out_d    = cur_byte_q[bit_cnt_q];
`else
        data_out_d    = cur_byte_q[3'd7 - bit_cnt_q];
`endif
        sync_out_d    = (bit_cnt_q == 3'd0);
        active_out_d  = cur_is_data_q;
        if (boundary) begin
            if (state_q == INIT && !last_init) begin
                cur_byte_d    = COM_CHAR;
                cur_is_data_d = 1'b0;
                com_cnt_d     = com_cnt_q + 4'd1;
            end else if (valid_in) begin
                cur_byte_d    = data_in;
                cur_is_data_d = 1'b1;
            end else begin
                cur_byte_d    = COM_CHAR;
                cur_is_data_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            bit_cnt_q     <= '0;
            cur_byte_q    <= COM_CHAR;
            cur_is_data_q <= 1'b0;
            com_cnt_q     <= '0;
            data_out_q    <= 1'b0;
            sync_out_q    <= 1'b0;
            active_out_q  <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            cur_byte_q    <= cur_byte_d;
            cur_is_data_q <= cur_is_data_d;
            com_cnt_q     <= com_cnt_d;
            data_out_q    <= data_out_d;
            sync_out_q    <= sync_out_d;
            active_out_q  <= active_out_d;
        end
    end

    assign data_out   = data_out_q;
    assign sync_out   = sync_out_q;
    assign active_out = active_out_q;

endmodule

// File: tb/tb_par_serial_tx.sv
`timescale 1ns/1ps
// Directed bench for par_serial_tx: startup COM run, data/COM stream, sampling window, mid-byte reset.
module tb_par_serial_tx;

    logic       clk_32f;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       sync_out;
    logic       active_out;

    int unsigned n_checks;
    int unsigned n_pass;

    par_serial_tx #(
        .COM_CHAR(8'hBC),
        .INIT_COM(4)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .sync_out  (sync_out),
        .active_out(active_out)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_32f);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        logic [2:0] idx;
`ifdef PS_LSB_FIRST_EN
        idx = 3'(i);
`else
        idx = 3'(7 - i);
`endif
        return b[idx];
    endfunction

    task automatic hold_reset(input string tag, input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("%s.rst%0d.data", tag, i), 8'(data_out), 8'h00);
            check($sformatf("%s.rst%0d.sync", tag, i), 8'(sync_out), 8'h00);
            check($sformatf("%s.rst%0d.act", tag, i), 8'(active_out), 8'h00);
        end
        reset = 1'b1;
    endtask

    // Junk inputs are driven on every non-boundary edge; nxt_* is what the boundary edge samples.
    task automatic byte_out(input string tag, input logic [7:0] exp_byte, input logic exp_act,
                            input logic [7:0] junk_d, input logic junk_v,
                            input logic [7:0] nxt_d, input logic nxt_v);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                data_in  = nxt_d;
                valid_in = nxt_v;
            end else begin
                data_in  = junk_d;
                valid_in = junk_v;
            end
            step();
            check($sformatf("%s.b%0d.data", tag, i), 8'(data_out), 8'(exp_bit(exp_byte, i)));
            check($sformatf("%s.b%0d.sync", tag, i), 8'(sync_out), (i == 0) ? 8'h01 : 8'h00);
            check($sformatf("%s.b%0d.act", tag, i), 8'(active_out), 8'(exp_act));
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        data_in  = 8'h00;
        valid_in = 1'b0;

        // Startup with no valid data: four COM bytes, then COM inserted in RUN.
        hold_reset("t1", 3);
        for (int k = 0; k < 5; k++) begin
            byte_out($sformatf("t1.com%0d", k), 8'hBC, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        end

        // Valid data from release is ignored until the startup run is done.
        data_in  = 8'hA5;
        valid_in = 1'b1;
        hold_reset("t2", 2);
        for (int k = 0; k < 4; k++) begin
            byte_out($sformatf("t2.com%0d", k), 8'hBC, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1);
        end
        byte_out("t2.a5", 8'hA5, 1'b1, 8'h5A, 1'b0, 8'h0F, 1'b1);

        // RUN stream: data, idle COM, data equal to COM_CHAR.
        byte_out("t3.0f", 8'h0F, 1'b1, 8'h55, 1'b1, 8'h00, 1'b0);
        byte_out("t3.idle", 8'hBC, 1'b0, 8'h77, 1'b1, 8'hBC, 1'b1);
        byte_out("t3.bcdata", 8'hBC, 1'b1, 8'h11, 1'b0, 8'h3C, 1'b1);

        // Input changes right after the boundary do not affect the byte in flight.
        byte_out("t4.3c", 8'h3C, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1);
        byte_out("t4.ff", 8'hFF, 1'b1, 8'h00, 1'b0, 8'h01, 1'b1);
        byte_out("t6.01", 8'h01, 1'b1, 8'h00, 1'b0, 8'h81, 1'b1);

        // Reset at bit_cnt==3 of a 0x81 byte aborts it and restarts the COM run.
        data_in  = 8'h00;
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5.part%0d.data", i), 8'(data_out), 8'(exp_bit(8'h81, i)));
            check($sformatf("t5.part%0d.act", i), 8'(active_out), 8'h01);
        end
        data_in  = 8'h81;
        valid_in = 1'b1;
        hold_reset("t5", 2);
        for (int k = 0; k < 4; k++) begin
            byte_out($sformatf("t5.com%0d", k), 8'hBC, 1'b0, 8'h81, 1'b1, 8'h81, 1'b1);
        end
        byte_out("t5.81", 8'h81, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        byte_out("t5.idle", 8'hBC, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/par_serial_tx.md
Name: par_serial_tx

Overview:
Parallel-to-serial converter directly downstream of the phy_tx 4:1 byte mux. It takes the mux's 8-bit output and valid and shifts it out one bit per clk_32f cycle, MSB first. It inserts the COM character (0xBC) whenever the mux has no valid byte. After reset it sends a fixed startup run of COM bytes so the receiver can align.

Parameters:
COM_CHAR, 8'hBC, idle/alignment byte inserted when no valid data; also sent during startup.
INIT_COM, 4, number of COM bytes sent after reset before data is accepted (legal range 1..15).

Ports:
clk_32f  input  1  serial bit clock, 8x the mux output (clk_4f) rate; all logic on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clk_32f
data_in  input  8  byte from the mux (mux Salida)
valid_in  input  1  data_in qualifier (mux validsalida)
data_out  output  1  registered serial bit stream
sync_out  output  1  registered one-cycle pulse marking the first bit of every byte on data_out
active_out  output  1  registered; 1 while data_out carries a data byte, 0 while it carries an inserted COM

Behaviour:
- Reset (reset==0 at a rising edge): data_out=0, sync_out=0, active_out=0.
- Reset internal state: bit_cnt=0, cur_byte=COM_CHAR, cur_is_data=0, state=INIT, com_cnt=0.
- Reset mid-byte aborts the byte immediately. No partial byte is completed.
- bit_cnt is a 3-bit free-running counter that wraps 7->0. One byte takes 8 cycles.
- Every non-reset edge:
  - data_out <= cur_byte[7-bit_cnt]
  - sync_out <= (bit_cnt==0)
  - active_out <= cur_is_data
- Byte boundary is the edge where bit_cnt==7. At that edge cur_byte and cur_is_data are reloaded according to the current state:
  - INIT, com_cnt!=INIT_COM-1: load COM_CHAR, cur_is_data=0, com_cnt++.
  - INIT, com_cnt==INIT_COM-1: state<=RUN. The load at this same edge follows the RUN rule.
  - RUN, valid_in==1: load data_in, cur_is_data=1.
  - RUN, valid_in==0: load COM_CHAR, cur_is_data=0.
- data_in and valid_in are only sampled at the boundary edge. Values at all other edges are ignored.
- Exactly INIT_COM COM bytes are sent after reset, counting the reset-loaded byte, before the first byte that can be data.
- Latency: a byte sampled at boundary edge E appears as follows.
  - Its bit 7 is on data_out after edge E+1, with sync_out=1 in the same cycle.
  - Its bit 0 is on data_out after edge E+8.
- A data byte equal to COM_CHAR with valid_in=1 is sent as data (active_out=1). The block does not escape it.
- RUN is terminal. Only reset returns the block to INIT.
- First edge after reset release: data_out=COM_CHAR[7]=1, sync_out=1, active_out=0.
- FSM encoding: INIT=0, RUN=1. com_cnt is 4 bits.

Optional Feature:
Macro PS_LSB_FIRST_EN.
- Defined: bit order is reversed, so data_out <= cur_byte[bit_cnt] and bits go out LSB first. sync_out still marks the first transmitted bit (now bit 0). Timing, FSM and COM insertion are unchanged.
- Undefined: MSB first, as described above.

Test Plan:
1. Hold reset=0 for 3 cycles, then release with valid_in=0 -> data_out, sync_out and active_out are 0 during reset. Then 4 repeats of 1,0,1,1,1,1,0,0 follow. sync_out pulses every 8th cycle starting at cycle 1. active_out stays 0.
2. Startup gating: valid_in=1, data_in=8'hA5 from reset release -> the first 4 bytes are 0xBC despite valid_in. The 5th byte is 1,0,1,0,0,1,0,1 with active_out=1 for those 8 cycles.
3. RUN stream: at successive boundaries apply 8'h0F valid, then 8'h00 with valid_in=0, then 8'hBC valid -> serial output 0x0F, 0xBC, 0xBC. active_out reads 1, 0, 1 per byte.
4. Sampling window: in RUN, change data_in from 8'h3C to 8'hFF one cycle after the boundary edge -> 0x3C is sent. 0xFF is sent only if still present at the next boundary.
5. Reset mid-byte: assert reset=0 at bit_cnt==3 of a 0x81 data byte -> the byte is truncated and outputs go to 0. After release the INIT sequence of 4 COM bytes restarts.
6. Compile with PS_LSB_FIRST_EN and send 8'h01 in RUN -> data_out is 1,0,0,0,0,0,0,0 with sync_out on the first bit. COM bytes go out as 0,0,1,1,1,1,0,1.
